alu_exec_sequencer: RTL
=======================

Name: alu_exec_sequencer

Overview:
- Multi-cycle execution sequencer for the 32-bit core. It sits between instruction issue and the datapath formed by the register bank, ALUControl and ALU.
- Accepts one decoded instruction per handshake, reads operands from the register bank and drives ALUOp/funct to ALUControl.
- Starts and waits on the multi-cycle MULT/DIV unit, then writes the result back.
- Flags illegal funct codes and MULT/DIV timeouts.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register-bank address width.
- IMM_W, 16, MOVI immediate width.
- MDU_TIMEOUT, 64, maximum cycles spent waiting for mdu_done.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept.
- instr_is_movi  in  1  1 = MOVI (ALUOp 00), 0 = R-type (ALUOp 10).
- instr_funct  in  6  R-type function code.
- instr_rs, instr_rt, instr_rd  in  ADDR_W each  source and destination registers.
- instr_imm  in  IMM_W  MOVI immediate.
- rf_ra1, rf_ra2  out  ADDR_W  register-bank read addresses.
- rf_rd1, rf_rd2  in  DATA_W  register-bank read data (combinational).
- alu_op  out  2  to ALUControl.ALUOp.
- alu_funct  out  6  to ALUControl.funct.
- alu_a, alu_b  out  DATA_W  ALU operands.
- alu_result  in  DATA_W  ALU / MULT-DIV result.
- mdu_start  out  1  one-cycle start pulse for MULT/DIV.
- mdu_done  in  1  MULT/DIV result valid.
- rf_we  out  1  write enable.
- rf_wa  out  ADDR_W  write address.
- rf_wd  out  DATA_W  write data.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse on a completed write-back.
- err_illegal  out  1  one-cycle pulse on an undefined funct.
- err_timeout  out  1  one-cycle pulse on an MDU timeout.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0 except instr_ready=1. Internal registers and counter cleared. An in-flight instruction is discarded with no write-back. mdu_start drops immediately.
- Funct codes: ADD 100000, SUB 100100, MULT 100001, DIV 100010, MOV 100011. Any other code is illegal when instr_is_movi=0.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready: latch all instr_* fields, go to READ.
  - instr_ready=0 in every other state; no skid buffer.
- READ:
  - rf_ra1=rs, rf_ra2=rt; latch rf_rd1/rf_rd2.
  - Illegal funct -> ERR with err_illegal pulse.
  - Otherwise -> EXEC.
- EXEC:
  - alu_op = 00 (MOVI) or 10 (R-type); alu_funct = latched funct (000000 for MOVI).
  - alu_a/alu_b: R-type = latched operands. MOVI: alu_a = 0, alu_b = sign-extended imm.
  - ADD/SUB/MOV/MOVI: latch alu_result, go to WB.
  - MULT/DIV: mdu_start=1 for this single cycle, go to MDU_WAIT.
- MDU_WAIT:
  - Hold alu_op, alu_funct, alu_a and alu_b stable.
  - The timeout counter starts at 0 and increments each cycle.
  - mdu_done=1: latch alu_result, go to WB.
  - Counter==MDU_TIMEOUT-1 without mdu_done: go to ERR with err_timeout pulse.
  - mdu_done asserted during EXEC is ignored.
- WB:
  - rf_we=1, rf_wa=rd, rf_wd=result, done=1. Go to IDLE.
  - rd==0: rf_we is forced to 0 (R0 read-only), but done still pulses.
- ERR: one cycle; the err pulse is emitted on ERR entry. No write-back. Go to IDLE.
- Latency, accept edge to WB cycle: 3 cycles for single-cycle ops. MULT/DIV: 3 + k cycles, where mdu_done arrives k ≥ 1 cycles after mdu_start.
- Throughput: one instruction in flight. The next instruction can be accepted in the cycle after WB or ERR.
- busy = (state != IDLE).
- alu_* outputs are 0 outside EXEC and MDU_WAIT.
- rf_ra* are 0 outside READ.

Decomposition:
- Shared header/package alu_defs holds:
  - funct constants;
  - ALUOp codes (ALUOP_MOVI=00, ALUOP_RTYPE=10);
  - state encoding IDLE/READ/EXEC/MDU_WAIT/WB/ERR.
- ALUControl reuses the same constants.
- Sub-module seq_timeout_counter: clear/enable inputs plus an expired flag, parameterised by MDU_TIMEOUT.

Test Plan:
- MOVI: rd=3, imm=16'hFFF0, accepted at cycle 0 -> alu_op=00 at cycle 2; rf_we=1, rf_wa=3, rf_wd=32'hFFFFFFF0 at cycle 3; done pulses.
- ADD: rs=1 (5), rt=2 (7), rd=4 -> alu_op=10, alu_funct=100000, alu_a=5, alu_b=7; rf_wd = ALU model result 12 at cycle 3.
- MULT: mdu_done returned 4 cycles after mdu_start with result 35 -> exactly one mdu_start pulse; write-back of 35 to rd in the cycle after mdu_done.
- Illegal funct 111111 -> err_illegal pulse at cycle 2, no rf_we, instr_ready high by cycle 3.
- DIV with mdu_done never asserted, MDU_TIMEOUT=8 -> err_timeout exactly 8 cycles into MDU_WAIT, no write-back. A later mdu_done while IDLE is ignored.
- Reset mid-op: rst asserted during MDU_WAIT -> outputs 0 immediately (asynchronous), instr_ready=1, no write-back. Write to rd=0 -> done=1, rf_we=0.

Source files
------------

// File: rtl/alu_defs.sv
// alu_defs -- constants shared by the execution sequencer and ALUControl.
//   * R-type function codes recognised by the datapath
//   * ALUOp encodings driven into ALUControl
//   * sequencer state encoding
//   * small decode helpers for function-code classification
package alu_defs;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100100;
  localparam logic [5:0] FUNCT_MULT = 6'b100001;
  localparam logic [5:0] FUNCT_DIV  = 6'b100010;
  localparam logic [5:0] FUNCT_MOV  = 6'b100011;

  localparam logic [1:0] ALUOP_MOVI  = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    EXEC     = 3'd2,
    MDU_WAIT = 3'd3,
    WB       = 3'd4,
    ERR      = 3'd5
  } seq_state_t;

  function automatic logic funct_is_legal(input logic [5:0] funct);
    return (funct == FUNCT_ADD)  || (funct == FUNCT_SUB) ||
           (funct == FUNCT_MULT) || (funct == FUNCT_DIV) ||
           (funct == FUNCT_MOV);
  endfunction

  // MULT and DIV go through the multi-cycle unit rather than the ALU.
  function automatic logic funct_is_mdu(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// seq_timeout_counter -- bounded wait counter for the MULT/DIV handshake.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : force the count back to 0
//   enable    : count this cycle (one cycle of waiting)
//   expired   : high during the MDU_TIMEOUT-th enabled cycle since clear
module seq_timeout_counter #(
  parameter int MDU_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MDU_TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  // Saturates at LAST so the count can never wrap back below the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer -- multi-cycle execution sequencer for the 32-bit core.
// Takes one decoded instruction per valid/ready handshake, reads operands
// from the register bank, drives ALUControl/ALU, optionally runs the
// MULT/DIV unit, and writes the result back.
// Ports:
//   instr_*            : decoded instruction and handshake
//   rf_ra1/2, rf_rd1/2 : register-bank read (combinational data)
//   alu_op/funct/a/b   : ALUControl and ALU operands; alu_result comes back
//   mdu_start/done     : MULT/DIV start pulse and result-valid
//   rf_we/wa/wd        : register-bank write port
//   busy, done         : status; done pulses on write-back
//   err_illegal/timeout: one-cycle error pulses
module alu_exec_sequencer
  import alu_defs::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int IMM_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_is_movi,
  input  logic [5:0]        instr_funct,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [ADDR_W-1:0] instr_rt,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [IMM_W-1:0]  instr_imm,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [1:0]        alu_op,
  output logic [5:0]        alu_funct,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              mdu_start,
  input  logic              mdu_done,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_timeout
);

  seq_state_t        state_reg, state_next;
  logic              movi_reg;
  logic [5:0]        funct_reg;
  logic [ADDR_W-1:0] rs_reg, rt_reg, rd_reg;
  logic [IMM_W-1:0]  imm_reg;
  logic [DATA_W-1:0] op_a_reg, op_b_reg, result_reg;
  logic              err_is_timeout_reg;   // which error caused ERR

  logic              is_illegal, is_mdu, tmo_expired;
  logic [DATA_W-1:0] imm_ext;

  assign is_illegal = !movi_reg && !funct_is_legal(funct_reg);
  assign is_mdu     = !movi_reg && funct_is_mdu(funct_reg);
  assign imm_ext    = {{(DATA_W-IMM_W){imm_reg[IMM_W-1]}}, imm_reg};

  // Counts cycles spent in MDU_WAIT; held at zero everywhere else.
  seq_timeout_counter #(.MDU_TIMEOUT(MDU_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_reg != MDU_WAIT),
    .enable  (state_reg == MDU_WAIT),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (instr_valid) state_next = READ;
      READ:     state_next = is_illegal ? ERR : EXEC;
      EXEC:     state_next = is_mdu ? MDU_WAIT : WB;
      // mdu_done wins over an expiry landing in the same cycle.
      MDU_WAIT: if (mdu_done)         state_next = WB;
                else if (tmo_expired) state_next = ERR;
      WB:       state_next = IDLE;
      ERR:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      movi_reg           <= 1'b0;
      funct_reg          <= '0;
      rs_reg             <= '0;
      rt_reg             <= '0;
      rd_reg             <= '0;
      imm_reg            <= '0;
      op_a_reg           <= '0;
      op_b_reg           <= '0;
      result_reg         <= '0;
      err_is_timeout_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && instr_valid) begin
        movi_reg  <= instr_is_movi;
        funct_reg <= instr_funct;
        rs_reg    <= instr_rs;
        rt_reg    <= instr_rt;
        rd_reg    <= instr_rd;
        imm_reg   <= instr_imm;
      end
      if (state_reg == READ) begin
        op_a_reg <= rf_rd1;
        op_b_reg <= rf_rd2;
      end
      if ((state_reg == EXEC && !is_mdu) || (state_reg == MDU_WAIT && mdu_done)) begin
        result_reg <= alu_result;
      end
      if (state_next == ERR) begin
        err_is_timeout_reg <= (state_reg == MDU_WAIT);
      end
    end
  end

  always_comb begin
    instr_ready = (state_reg == IDLE);
    busy        = (state_reg != IDLE);
    rf_ra1      = '0;
    rf_ra2      = '0;
    alu_op      = 2'b00;
    alu_funct   = 6'b000000;
    alu_a       = '0;
    alu_b       = '0;
    mdu_start   = 1'b0;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    done        = 1'b0;
    err_illegal = 1'b0;
    err_timeout = 1'b0;

    if (state_reg == READ) begin
      rf_ra1 = rs_reg;
      rf_ra2 = rt_reg;
    end
    // Operands stay stable across EXEC and the whole MDU wait.
    if (state_reg == EXEC || state_reg == MDU_WAIT) begin
      alu_op    = movi_reg ? ALUOP_MOVI : ALUOP_RTYPE;
      alu_funct = movi_reg ? 6'b000000 : funct_reg;
      alu_a     = movi_reg ? '0 : op_a_reg;
      alu_b     = movi_reg ? imm_ext : op_b_reg;
    end
    if (state_reg == EXEC) mdu_start = is_mdu;
    if (state_reg == WB) begin
      rf_we = (rd_reg != '0);          // R0 is read-only
      rf_wa = rd_reg;
      rf_wd = result_reg;
      done  = 1'b1;
    end
    if (state_reg == ERR) begin
      err_illegal = !err_is_timeout_reg;
      err_timeout = err_is_timeout_reg;
    end
  end

endmodule
